// File: rtl/ps2_pkg.sv
// ps2_pkg: scancode constants, receiver states and the Lynx key/hotkey maps.
package ps2_pkg;
  localparam logic [7:0] SC_REL = 8'hF0, SC_EXT = 8'hE0, SC_PAUSE = 8'hE1, SC_BAT = 8'hAA;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef struct packed {logic hit; logic [3:0] row; logic [2:0] col;} key_t;
  function automatic key_t at(input int r, input int c);
    return '{1'b1, 4'(r), 3'(c)};
  endfunction
  // Keypad 75/72/6B/74 deliberately alias the extended cursor keys.
  function automatic key_t keymap(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h016: return at(0, 0);  9'h058: return at(0, 3);  9'h175: return at(0, 4);
      9'h075: return at(0, 4);  9'h172: return at(0, 5);  9'h072: return at(0, 5);
      9'h076: return at(0, 6);  9'h012: return at(0, 7);  9'h059: return at(0, 7);
      9'h026: return at(1, 0);  9'h025: return at(1, 1);  9'h024: return at(1, 2);
      9'h022: return at(1, 3);  9'h023: return at(1, 4);  9'h021: return at(1, 5);
      9'h01E: return at(2, 0);  9'h015: return at(2, 1);  9'h01D: return at(2, 2);
      9'h01A: return at(2, 3);  9'h01B: return at(2, 4);  9'h01C: return at(2, 5);
      9'h014: return at(2, 6);  9'h114: return at(2, 6);
      9'h02E: return at(3, 0);  9'h02D: return at(3, 1);  9'h02C: return at(3, 2);
      9'h02A: return at(3, 3);  9'h034: return at(3, 4);  9'h02B: return at(3, 5);
      9'h036: return at(4, 0);  9'h035: return at(4, 1);  9'h033: return at(4, 2);
      9'h029: return at(4, 3);  9'h031: return at(4, 4);  9'h032: return at(4, 5);
      9'h03D: return at(5, 0);  9'h03E: return at(5, 1);  9'h03C: return at(5, 2);
      9'h03A: return at(5, 3);  9'h03B: return at(5, 4);
      9'h046: return at(6, 0);  9'h043: return at(6, 1);  9'h044: return at(6, 2);
      9'h041: return at(6, 3);  9'h042: return at(6, 4);
      9'h045: return at(7, 0);  9'h04D: return at(7, 1);  9'h04B: return at(7, 2);
      9'h049: return at(7, 3);
      9'h04E: return at(8, 0);  9'h054: return at(8, 1);  9'h04C: return at(8, 2);
      9'h04A: return at(8, 3);  9'h052: return at(8, 4);
      9'h066: return at(9, 0);  9'h05B: return at(9, 1);  9'h16B: return at(9, 2);
      9'h06B: return at(9, 2);  9'h05A: return at(9, 3);  9'h174: return at(9, 5);
      9'h074: return at(9, 5);
      default: return '0;
    endcase
  endfunction
  // Hotkey latch bits: {BkSp, Del, RAlt, RCtrl, LCtrl, F12, F11, F8}.
  function automatic logic [7:0] hotkey(input logic ext, input logic [7:0] code);
    return {!ext && code == 8'h66, ext && code == 8'h71, ext && code == 8'h11, ext && code == 8'h14,
            !ext && code == 8'h14, !ext && code == 8'h07, !ext && code == 8'h78, !ext && code == 8'h0A};
  endfunction
endpackage

// File: rtl/ps2_matrix_rx.sv
// ps2_rx: PS/2 clock filter, falling-edge detect, frame FSM and frame watchdog.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 2000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       ce_i,
  input  logic [1:0] ps2_i,
  output logic [7:0] code_o,
  output logic       code_valid_o,
  output logic       frame_err_o
);
  localparam int WW = $clog2(TIMEOUT + 1);
  rx_state_e st_q;
  logic [7:0] flt_q, sh_q, code_q;
  logic [2:0] cnt_q;
  logic [WW-1:0] wd_q;
  logic lvl_q, dat_q, par_q, valid_q, err_q;
  logic fall;
  assign fall = lvl_q && flt_q == 8'h00;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      st_q <= RX_IDLE;
      flt_q <= '1;
      lvl_q <= 1'b1;
      dat_q <= 1'b1;
      sh_q <= '0;
      par_q <= 1'b0;
      cnt_q <= '0;
      wd_q <= '0;
      code_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else if (ce_i) begin
      flt_q <= {flt_q[6:0], ps2_i[0]};
      dat_q <= ps2_i[1];
      lvl_q <= flt_q == 8'hFF ? 1'b1 : flt_q == 8'h00 ? 1'b0 : lvl_q;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      wd_q <= (fall || st_q == RX_IDLE) ? '0 : wd_q + WW'(1);
      if (fall)
        case (st_q)
          RX_IDLE: if (!dat_q) begin
            st_q <= RX_DATA;
            cnt_q <= '0;
          end
          RX_DATA: begin
            sh_q <= {dat_q, sh_q[7:1]};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) st_q <= RX_PARITY;
          end
          RX_PARITY: begin
            par_q <= dat_q;
            st_q <= RX_STOP;
          end
          RX_STOP: begin
            st_q <= RX_IDLE;
            valid_q <= dat_q && ^{sh_q, par_q};
            err_q <= !(dat_q && ^{sh_q, par_q});
            if (dat_q && ^{sh_q, par_q}) code_q <= sh_q;
          end
        endcase
      else if (st_q != RX_IDLE && wd_q == WW'(TIMEOUT - 1)) begin
        st_q <= RX_IDLE;
        err_q <= 1'b1;
      end
    end
  assign code_o = code_q;
  assign code_valid_o = valid_q;
  assign frame_err_o = err_q;
endmodule

// File: rtl/ps2_matrix.sv
// ps2_matrix: PS/2 scancode decoder driving the active-low Lynx key matrix and hotkeys.
module ps2_matrix
  import ps2_pkg::*;
#(
  parameter int ROWS    = 10,
  parameter int COLS    = 8,
  parameter int RW      = $clog2(ROWS),
  parameter int TIMEOUT = 2000
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            ce_i,
  input  logic [1:0]      ps2_i,
  input  logic [RW-1:0]   row_i,
  output logic [COLS-1:0] do_o,
  output logic [7:0]      code_o,
  output logic            code_valid_o,
  output logic            frame_err_o,
  output logic            rst_key_o,
  output logic            boot_key_o,
  output logic            cas_key_o
);
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  logic [COLS-1:0] mat_q [ROWS];
  logic [7:0] hk_q, hm;
  logic [2:0] skip_q;
  logic rel_q, ext_q, hit, ignore, ctrl;
  key_t km;
  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clock_i, .reset_i, .ce_i, .ps2_i, .code_o, .code_valid_o, .frame_err_o
  );
  assign km = keymap(ext_q, code_o);
  assign hm = hotkey(ext_q, code_o);
  assign hit = km.hit && int'(km.row) < ROWS && int'(km.col) < COLS;
  assign ignore = code_o inside {8'hFA, 8'hFE, 8'h00, 8'hFF};
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      for (int r = 0; r < ROWS; r++) mat_q[r] <= '1;
      hk_q <= '1;
      rel_q <= 1'b0;
      ext_q <= 1'b0;
      skip_q <= '0;
    end else if (ce_i && code_valid_o) begin
      if (skip_q != 3'd0) skip_q <= skip_q - 3'd1;
      else if (code_o == SC_PAUSE) begin
        skip_q <= 3'd7;
        rel_q <= 1'b0;
        ext_q <= 1'b0;
      end else if (code_o == SC_REL) rel_q <= 1'b1;
      else if (code_o == SC_EXT) ext_q <= 1'b1;
      else if (code_o == SC_BAT) begin
        for (int r = 0; r < ROWS; r++) mat_q[r] <= '1;
        hk_q <= '1;
      end else if (!ignore) begin
        if (hit) mat_q[RW'(km.row)][CW'(km.col)] <= rel_q;
        hk_q <= (hk_q & ~hm) | ({8{rel_q}} & hm);
        rel_q <= 1'b0;
        ext_q <= 1'b0;
      end
    end
  // Latches are active-low, so AND means "either pressed".
  assign ctrl = hk_q[3] & hk_q[4];
  assign cas_key_o = hk_q[0];
  assign boot_key_o = hk_q[1] & (ctrl | hk_q[5] | hk_q[7]);
  assign rst_key_o = hk_q[2] & (ctrl | hk_q[5] | hk_q[6]);
  assign do_o = int'(row_i) < ROWS ? mat_q[row_i] : '1;
endmodule
